// File: rtl/ibi_packer_if.sv
// IBI byte-stream and packed-word bus for ibi_packer.
// slave: the packer side; master: the producer/consumer side.
interface ibi_packer_if;
    logic [7:0]  i_transfer;
    logic        i_transfer_valid;
    logic        i_transfer_first;
    logic        i_transfer_last;
    logic [31:0] o_ibi_data;
    logic [3:0]  o_ibi_keep;
    logic        o_ibi_last;
    logic        o_ibi_valid;
    logic        i_ibi_ready;
    logic        o_overflow;
    logic        o_error;

    modport slave (
        input  i_transfer, i_transfer_valid, i_transfer_first, i_transfer_last, i_ibi_ready,
        output o_ibi_data, o_ibi_keep, o_ibi_last, o_ibi_valid, o_overflow, o_error
    );

    modport master (
        output i_transfer, i_transfer_valid, i_transfer_first, i_transfer_last, i_ibi_ready,
        input  o_ibi_data, o_ibi_keep, o_ibi_last, o_ibi_valid, o_overflow, o_error
    );
endinterface

// File: rtl/ibi_packer.sv
// Packs IBI bytes into 32-bit words in a FIFO with atomic per-IBI commit; IBIs that do not fit
// are dropped whole. Optional drop counter enabled by defining IBI_PACKER_DROP_CNT_EN.
module ibi_packer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    ibi_packer_if.slave bus
`ifdef IBI_PACKER_DROP_CNT_EN
    ,
    output logic [7:0]  o_drop_count
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {StIdle, StCollect, StDrop} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rd_q, rd_d, spec_q, spec_d, commit_q, commit_d;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     asm_q, asm_d;
    logic [3:0]      keep_q, keep_d;
    logic            overflow_q, overflow_d, error_q, error_d;
    logic [36:0]     mem [DEPTH];

    logic            byte_v, last_b, start, accept, word_wr, full, mem_we;
    logic            valid, pop;
    logic [1:0]      eff_lane;
    logic [31:0]     word_data;
    logic [3:0]      word_keep;
    logic [PW-1:0]   base_spec, spec_inc;
    logic [36:0]     head;

    // A first byte always restarts collection from lane 0 at the last committed position.
    always_comb begin
        byte_v    = bus.i_transfer_valid;
        last_b    = bus.i_transfer_last;
        start     = byte_v & bus.i_transfer_first;
        accept    = start | (byte_v & (state_q == StCollect));
        eff_lane  = start ? 2'd0 : lane_q;
        base_spec = start ? commit_q : spec_q;
        word_data = (start ? 32'd0 : asm_q) | ({24'd0, bus.i_transfer} << {eff_lane, 3'b000});
        word_keep = (start ? 4'd0 : keep_q) | (4'b0001 << eff_lane);
        word_wr   = accept & ((eff_lane == 2'd3) | last_b);
        full      = (base_spec - rd_q) == PW'(DEPTH);
        spec_inc  = base_spec + PW'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= StIdle;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (word_wr && full)        state_d = last_b ? StIdle : StDrop;
            else if (word_wr && last_b) state_d = StIdle;
            else                        state_d = StCollect;
        end else if (byte_v && last_b && (state_q == StDrop)) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        spec_d     = spec_q;
        commit_d   = commit_q;
        lane_d     = lane_q;
        asm_d      = asm_q;
        keep_d     = keep_q;
        mem_we     = 1'b0;
        overflow_d = 1'b0;
        error_d    = start & (state_q != StIdle);
        if (accept) begin
            if (word_wr) begin
                lane_d = 2'd0;
                asm_d  = 32'd0;
                keep_d = 4'd0;
                if (full) begin
                    spec_d     = commit_q;
                    overflow_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    spec_d = spec_inc;
                    if (last_b) commit_d = spec_inc;
                end
            end else begin
                lane_d = eff_lane + 2'd1;
                asm_d  = word_data;
                keep_d = word_keep;
                spec_d = base_spec;
            end
        end
    end

    assign valid = (commit_q != rd_q);
    assign pop   = valid & bus.i_ibi_ready;
    assign rd_d  = pop ? rd_q + PW'(1) : rd_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_q       <= '0;
            spec_q     <= '0;
            commit_q   <= '0;
            lane_q     <= 2'd0;
            asm_q      <= 32'd0;
            keep_q     <= 4'd0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            spec_q     <= spec_d;
            commit_q   <= commit_d;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            keep_q     <= keep_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[base_spec[AW-1:0]] <= {last_b, word_keep, word_data};
    end

    // Gate the head with valid so the storage needs no reset and outputs read 0 when empty.
    assign head            = mem[rd_q[AW-1:0]];
    assign bus.o_ibi_valid = valid;
    assign bus.o_ibi_data  = valid ? head[31:0] : 32'd0;
    assign bus.o_ibi_keep  = valid ? head[35:32] : 4'd0;
    assign bus.o_ibi_last  = valid & head[36];
    assign bus.o_overflow  = overflow_q;
    assign bus.o_error     = error_q;

`ifdef IBI_PACKER_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                                drop_cnt_q <= 8'd0;
        else if (overflow_d && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end

    assign o_drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ibi_packer.sv
// Directed self-checking bench for ibi_packer (DEPTH=4).
module tb_ibi_packer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    ibi_packer_if bus ();
`ifdef IBI_PACKER_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    ibi_packer #(.DEPTH(4)) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .bus(bus)
`ifdef IBI_PACKER_DROP_CNT_EN
        ,
        .o_drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] b, input logic f, input logic l);
        bus.i_transfer       = b;
        bus.i_transfer_valid = 1'b1;
        bus.i_transfer_first = f;
        bus.i_transfer_last  = l;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.i_transfer_valid = 1'b0;
        bus.i_transfer_first = 1'b0;
        bus.i_transfer_last  = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        logic [40:0] outs;
        rst_n = 1'b0;
        bus.i_transfer = 8'h00; bus.i_ibi_ready = 1'b0;
        bus.i_transfer_valid = 1'b0; bus.i_transfer_first = 1'b0; bus.i_transfer_last = 1'b0;
        #3;
        outs = {bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last, bus.o_ibi_valid,
                bus.o_overflow, bus.o_error};
        n_cmp++; if (outs !== 41'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
`ifdef IBI_PACKER_DROP_CNT_EN
        n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
`endif
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.o_ibi_valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle_valid: got %b want 0", bus.o_ibi_valid); end
    endtask

    task automatic test_single();
        bus.i_ibi_ready = 1'b1;
        send(8'h05, 1'b1, 1'b0);
        n_cmp++; if (bus.o_ibi_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", bus.o_ibi_valid); end
        send(8'hA5, 1'b0, 1'b1);
        n_cmp++; if (bus.o_ibi_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", bus.o_ibi_valid); end
        n_cmp++; if ({bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last} !== {32'h0000A505, 4'b0011, 1'b1}) begin
            n_bad++; $display("FAIL single_word: got %h/%b/%b want 0000a505/0011/1", bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last); end
        idle(1);
        n_cmp++; if (bus.o_ibi_valid !== 1'b0) begin n_bad++; $display("FAIL single_one_cycle: got %b want 0", bus.o_ibi_valid); end
        bus.i_ibi_ready = 1'b0;
    endtask

    task automatic test_multi_word();
        send(8'h05, 1'b1, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        n_cmp++; if (bus.o_ibi_valid !== 1'b0) begin n_bad++; $display("FAIL multi_uncommitted: got %b want 0", bus.o_ibi_valid); end
        send(8'h44, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b1);
        n_cmp++; if ({bus.o_ibi_valid, bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last} !== {1'b1, 32'h33221105, 4'b1111, 1'b0}) begin
            n_bad++; $display("FAIL multi_word0: got %b/%h/%b/%b want 1/33221105/1111/0", bus.o_ibi_valid, bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last); end
        bus.i_ibi_ready = 1'b1;
        idle(1);
        n_cmp++; if ({bus.o_ibi_valid, bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last} !== {1'b1, 32'h00005544, 4'b0011, 1'b1}) begin
            n_bad++; $display("FAIL multi_word1: got %b/%h/%b/%b want 1/00005544/0011/1", bus.o_ibi_valid, bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last); end
        idle(1);
        n_cmp++; if (bus.o_ibi_valid !== 1'b0) begin n_bad++; $display("FAIL multi_drained: got %b want 0", bus.o_ibi_valid); end
        bus.i_ibi_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int pulses;
        logic [7:0] bv;
        // Empty FIFO: the fifth word (last byte) finds it full.
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            bv = 8'(32'h20 + i);
            send(bv, i == 0, i == 16);
            pulses += int'(bus.o_overflow);
            n_cmp++; if (bus.o_ibi_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_valid_byte%0d: got %b want 0", i, bus.o_ibi_valid); end
        end
        idle(2);
        pulses += int'(bus.o_overflow);
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ovf_pulse_count: got %0d want 1", pulses); end
        send(8'h0B, 1'b1, 1'b0);
        send(8'hC3, 1'b0, 1'b1);
        n_cmp++; if ({bus.o_ibi_valid, bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last} !== {1'b1, 32'h0000C30B, 4'b0011, 1'b1}) begin
            n_bad++; $display("FAIL ovf_after_word: got %b/%h/%b/%b want 1/0000c30b/0011/1", bus.o_ibi_valid, bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last); end
`ifdef IBI_PACKER_DROP_CNT_EN
        n_cmp++; if (drop_count !== 8'd1) begin n_bad++; $display("FAIL ovf_drop_count1: got %0d want 1", drop_count); end
`endif
        // One word held: overflow hits mid-IBI, remaining bytes go through the drop state.
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            bv = 8'(32'h40 + i);
            send(bv, i == 0, i == 16);
            pulses += int'(bus.o_overflow);
        end
        idle(1);
        pulses += int'(bus.o_overflow);
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ovf_drop_pulse_count: got %0d want 1", pulses); end
        n_cmp++; if ({bus.o_ibi_valid, bus.o_ibi_data} !== {1'b1, 32'h0000C30B}) begin
            n_bad++; $display("FAIL ovf_head_kept: got %b/%h want 1/0000c30b", bus.o_ibi_valid, bus.o_ibi_data); end
`ifdef IBI_PACKER_DROP_CNT_EN
        n_cmp++; if (drop_count !== 8'd2) begin n_bad++; $display("FAIL ovf_drop_count2: got %0d want 2", drop_count); end
`endif
        bus.i_ibi_ready = 1'b1;
        idle(1);
        n_cmp++; if (bus.o_ibi_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", bus.o_ibi_valid); end
        bus.i_ibi_ready = 1'b0;
    endtask

    task automatic test_framing();
        send(8'h05, 1'b1, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h07, 1'b1, 1'b0);
        n_cmp++; if (bus.o_error !== 1'b1) begin n_bad++; $display("FAIL frame_error_pulse: got %b want 1", bus.o_error); end
        send(8'h22, 1'b0, 1'b1);
        n_cmp++; if (bus.o_error !== 1'b0) begin n_bad++; $display("FAIL frame_error_clear: got %b want 0", bus.o_error); end
        n_cmp++; if ({bus.o_ibi_valid, bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last} !== {1'b1, 32'h00002207, 4'b0011, 1'b1}) begin
            n_bad++; $display("FAIL frame_word: got %b/%h/%b/%b want 1/00002207/0011/1", bus.o_ibi_valid, bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last); end
        bus.i_ibi_ready = 1'b1;
        idle(1);
        n_cmp++; if (bus.o_ibi_valid !== 1'b0) begin n_bad++; $display("FAIL frame_only_one: got %b want 0", bus.o_ibi_valid); end
        bus.i_ibi_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [36:0] exp_w [3];
        int unstable;
        exp_w[0] = {1'b0, 4'b1111, 32'h04030201};
        exp_w[1] = {1'b1, 4'b0001, 32'h00000005};
        exp_w[2] = {1'b1, 4'b0011, 32'h00000706};
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        send(8'h04, 1'b0, 1'b0);
        send(8'h05, 1'b0, 1'b1);
        send(8'h06, 1'b1, 1'b0);
        send(8'h07, 1'b0, 1'b1);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if ({bus.o_ibi_valid, bus.o_ibi_last, bus.o_ibi_keep, bus.o_ibi_data} !== {1'b1, exp_w[0]}) unstable++;
            idle(1);
        end
        n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL bp_head_stable: got %0d bad cycles want 0", unstable); end
        bus.i_ibi_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({bus.o_ibi_valid, bus.o_ibi_last, bus.o_ibi_keep, bus.o_ibi_data} !== {1'b1, exp_w[i]}) begin
                n_bad++; $display("FAIL bp_word%0d: got %b/%b/%b/%h want 1/%h", i, bus.o_ibi_valid, bus.o_ibi_last, bus.o_ibi_keep, bus.o_ibi_data, exp_w[i]); end
            idle(1);
        end
        n_cmp++; if (bus.o_ibi_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", bus.o_ibi_valid); end
        bus.i_ibi_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [40:0] outs;
        send(8'h0D, 1'b1, 1'b0);
        send(8'hEE, 1'b0, 1'b1);
        send(8'h05, 1'b1, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        bus.i_transfer_valid = 1'b0; bus.i_transfer_first = 1'b0; bus.i_transfer_last = 1'b0;
        rst_n = 1'b0;
        #2;
        outs = {bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last, bus.o_ibi_valid,
                bus.o_overflow, bus.o_error};
        n_cmp++; if (outs !== 41'd0) begin n_bad++; $display("FAIL midrst_outputs: got %h want 0", outs); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.o_ibi_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_empty: got %b want 0", bus.o_ibi_valid); end
        send(8'h0F, 1'b1, 1'b0);
        n_cmp++; if (bus.o_error !== 1'b0) begin n_bad++; $display("FAIL midrst_no_error: got %b want 0", bus.o_error); end
        send(8'h3C, 1'b0, 1'b1);
        n_cmp++; if ({bus.o_ibi_valid, bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last} !== {1'b1, 32'h00003C0F, 4'b0011, 1'b1}) begin
            n_bad++; $display("FAIL midrst_word: got %b/%h/%b/%b want 1/00003c0f/0011/1", bus.o_ibi_valid, bus.o_ibi_data, bus.o_ibi_keep, bus.o_ibi_last); end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_word();
        test_overflow();
        test_framing();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
